req_ack_broadcast_responder: RTL and testbench



---
 rtl/req_ack_pkg.sv | 17 +
 rtl/req_ack_reader_port.sv | 51 +++++
 rtl/req_ack_broadcast_responder.sv | 125 ++++++++++++
 tb/tb_req_ack_broadcast_responder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/req_ack_pkg.sv
// Shared definitions for the req/ack broadcast responder: pointer width helper,
// statistics counter width and the per-reader pointer word type.
package req_ack_pkg;

    localparam int STATS_W   = 32;
    localparam int MAX_PTR_W = 32;

    // Pointer word wide enough for any supported DEPTH; per-reader pointer
    // arrays are declared as unpacked arrays of this type.
    typedef logic [MAX_PTR_W-1:0] ptr_word_t;

    // One extra bit beyond the address distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/req_ack_reader_port.sv
// One req/ack reader: private read pointer, one-cycle ack pulse and held data word.
module req_ack_reader_port #(
    parameter int DATA_WIDTH = 32,
    parameter int PTR_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [PTR_W-1:0]      wp,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [PTR_W-1:0]      rp
);

    logic [PTR_W-1:0]      rp_reg, rp_next;
    logic                  ack_reg, ack_next;
    logic [DATA_WIDTH-1:0] dout_reg, dout_next;
    logic                  avail;
    logic                  fire;

    always_comb begin
        avail     = (rp_reg != wp);
        // Blocking on ack_reg makes ack a single-cycle pulse.
        fire      = req & ~ack_reg & avail;
        rp_next   = rp_reg;
        ack_next  = fire;
        dout_next = dout_reg;
        if (fire) begin
            rp_next   = rp_reg + PTR_W'(1);
            dout_next = rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rp_reg   <= '0;
            ack_reg  <= 1'b0;
            dout_reg <= '0;
        end else begin
            rp_reg   <= rp_next;
            ack_reg  <= ack_next;
            dout_reg <= dout_next;
        end
    end

    assign ack  = ack_reg;
    assign dout = dout_reg;
    assign rp   = rp_reg;

endmodule

// File: rtl/req_ack_broadcast_responder.sv
// Buffered multi-reader req/ack responder; an entry retires once every reader has taken it.
// Optional statistics ports are enabled with REQ_ACK_BROADCAST_RESPONDER_STATS_EN.
module req_ack_broadcast_responder
    import req_ack_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int NUM_READERS = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    output logic                            wr_full,
    output logic                            empty,
    output logic [$clog2(DEPTH):0]          level,
    input  logic [NUM_READERS-1:0]          req,
    output logic [NUM_READERS-1:0]          ack,
`ifdef REQ_ACK_BROADCAST_RESPONDER_STATS_EN
    output logic [NUM_READERS*STATS_W-1:0]  count,
    output logic [STATS_W-1:0]              drop_count,
`endif
    output logic [NUM_READERS*DATA_WIDTH-1:0] dout
);

    localparam int PTR_W  = ptr_width(DEPTH);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]       wp_reg, wp_next;
    logic [PTR_W-1:0]       tail_reg, tail_next;
    logic [PTR_W-1:0]       level_w;
    logic [PTR_W-1:0]       rp_all [NUM_READERS];
    ptr_word_t              rp_ext [NUM_READERS];
    logic [DATA_WIDTH-1:0]  rd_data [NUM_READERS];
    logic [NUM_READERS-1:0] past_tail;
    logic                   wr_accept;
    logic                   retire;

    // Modular subtraction keeps level exact across any number of pointer wraps.
    assign level_w   = wp_reg - tail_reg;
    assign level     = level_w;
    assign wr_full   = (level_w == PTR_W'(DEPTH));
    assign empty     = (level_w == '0);
    assign wr_accept = wr_en & ~wr_full;
    assign retire    = ~empty & (&past_tail);

    generate
        for (genvar gi = 0; gi < NUM_READERS; gi++) begin : g_reader
            req_ack_reader_port #(
                .DATA_WIDTH (DATA_WIDTH),
                .PTR_W      (PTR_W)
            ) u_port (
                .clk     (clk),
                .rst     (rst),
                .req     (req[gi]),
                .wp      (wp_reg),
                .rd_data (rd_data[gi]),
                .ack     (ack[gi]),
                .dout    (dout[gi*DATA_WIDTH +: DATA_WIDTH]),
                .rp      (rp_all[gi])
            );
            assign rd_data[gi]   = mem[rp_all[gi][ADDR_W-1:0]];
            assign rp_ext[gi]    = ptr_word_t'(rp_all[gi]);
            assign past_tail[gi] = (rp_ext[gi] != ptr_word_t'(tail_reg));
        end
    endgenerate

    always_comb begin
        wp_next   = wp_reg;
        tail_next = tail_reg;
        if (wr_accept) begin
            wp_next = wp_reg + PTR_W'(1);
        end
        if (retire) begin
            tail_next = tail_reg + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp_reg   <= '0;
            tail_reg <= '0;
        end else begin
            wp_reg   <= wp_next;
            tail_reg <= tail_next;
        end
    end

    // Storage carries no reset; clearing the pointers discards its contents.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wp_reg[ADDR_W-1:0]] <= wr_data;
        end
    end

`ifdef REQ_ACK_BROADCAST_RESPONDER_STATS_EN
    logic [STATS_W-1:0] drop_reg;

    generate
        for (genvar gi = 0; gi < NUM_READERS; gi++) begin : g_stats
            logic [STATS_W-1:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    cnt_reg <= '0;
                end else if (ack[gi]) begin
                    cnt_reg <= cnt_reg + STATS_W'(1);
                end
            end
            assign count[gi*STATS_W +: STATS_W] = cnt_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_reg <= '0;
        end else if (wr_en & wr_full) begin
            drop_reg <= drop_reg + STATS_W'(1);
        end
    end

    assign drop_count = drop_reg;
`endif

endmodule

// File: tb/tb_req_ack_broadcast_responder.sv
// Scenario bench for req_ack_broadcast_responder: per-reader expected-word queues
// are filled on accepted pushes and drained by an ack monitor.
module tb_req_ack_broadcast_responder;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int NR    = 2;
    localparam int LW    = 3;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          wr_en   = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_full;
    logic          empty;
    logic [LW-1:0] level;
    logic [NR-1:0] req     = '0;
    logic [NR-1:0] ack;
    logic [NR*DW-1:0] dout;
`ifdef REQ_ACK_BROADCAST_RESPONDER_STATS_EN
    logic [NR*32-1:0] count;
    logic [31:0]      drop_count;
`endif

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] exp_q [NR][$];
    int            rx_cnt [NR];
    logic [NR-1:0] prev_ack = '0;

    always #5 clk = ~clk;

    req_ack_broadcast_responder #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .NUM_READERS (NR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_full    (wr_full),
        .empty      (empty),
        .level      (level),
        .req        (req),
        .ack        (ack),
`ifdef REQ_ACK_BROADCAST_RESPONDER_STATS_EN
        .count      (count),
        .drop_count (drop_count),
`endif
        .dout       (dout)
    );

    // Ack monitor: each ack pops the reader's expected word and checks pulse width.
    always @(negedge clk) begin
        for (int r = 0; r < NR; r++) begin
            if (ack[r] === 1'b1) begin
                logic [DW-1:0] e;
                logic [DW-1:0] got;
                got = dout[r*DW +: DW];
                n_cmp++;
                if (prev_ack[r] === 1'b1) begin
                    n_bad++;
                    $display("FAIL ack_pulse rd%0d: ack high two cycles running, required single pulse", r);
                end
                n_cmp++;
                if (exp_q[r].size() == 0) begin
                    n_bad++;
                    $display("FAIL ack_data rd%0d: unexpected ack with dout=%h, required no ack", r, got);
                end else begin
                    e = exp_q[r].pop_front();
                    if (got !== e) begin
                        n_bad++;
                        $display("FAIL ack_data rd%0d: dout=%h, required %h", r, got, e);
                    end else begin
                        $display("rd%0d ack dout=%h", r, got);
                    end
                end
                rx_cnt[r]++;
            end
        end
        prev_ack = ack;
    end

    task automatic push_exp(input logic [DW-1:0] d);
        for (int r = 0; r < NR; r++) exp_q[r].push_back(d);
    endtask

    task automatic do_reset(input int cyc);
        rst   = 1'b0;
        wr_en = 1'b0;
        req   = '0;
        repeat (cyc) @(negedge clk);
        for (int r = 0; r < NR; r++) begin
            exp_q[r].delete();
            rx_cnt[r] = 0;
        end
        rst = 1'b1;
    endtask

    task automatic wait_drain(input int r, input int budget, input string what);
        int k = 0;
        while (exp_q[r].size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (exp_q[r].size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain rd%0d: %0d words outstanding after %0d cycles, required 0",
                     what, r, exp_q[r].size(), budget);
        end
    endtask

    task automatic test_reset();
        do_reset(2);
        n_cmp++; if (ack !== '0)      begin n_bad++; $display("FAIL reset_ack: %b, required 0", ack); end
        n_cmp++; if (dout !== '0)     begin n_bad++; $display("FAIL reset_dout: %h, required 0", dout); end
        n_cmp++; if (wr_full !== 1'b0) begin n_bad++; $display("FAIL reset_full: %b, required 0", wr_full); end
        n_cmp++; if (empty !== 1'b1)  begin n_bad++; $display("FAIL reset_empty: %b, required 1", empty); end
        n_cmp++; if (level !== '0)    begin n_bad++; $display("FAIL reset_level: %0d, required 0", level); end
`ifdef REQ_ACK_BROADCAST_RESPONDER_STATS_EN
        n_cmp++; if (drop_count !== '0) begin n_bad++; $display("FAIL reset_drop: %0d, required 0", drop_count); end
`endif
    endtask

    task automatic test_basic();
        req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1'b1;
            wr_data = DW'(32'h10 + i);
            push_exp(wr_data);
            @(negedge clk);
        end
        wr_en = 1'b0;
        wait_drain(0, 40, "basic");
        wait_drain(1, 40, "basic");
        repeat (3) @(negedge clk);
        n_cmp++; if (level !== '0)   begin n_bad++; $display("FAIL basic_level: %0d, required 0", level); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL basic_empty: %b, required 1", empty); end
        for (int r = 0; r < NR; r++) begin
            n_cmp++;
            if (rx_cnt[r] != 3) begin n_bad++; $display("FAIL basic_count rd%0d: %0d words, required 3", r, rx_cnt[r]); end
        end
        req = '0;
    endtask

    task automatic test_overflow();
        do_reset(1);
        req = 2'b01;
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) begin
                n_cmp++;
                if (wr_full !== 1'b1) begin n_bad++; $display("FAIL ovf_full4: %b, required 1", wr_full); end
            end
            wr_en   = 1'b1;
            wr_data = DW'(i);
            if (i <= 4) push_exp(wr_data);
            @(negedge clk);
        end
        wr_en = 1'b0;
        n_cmp++; if (level !== LW'(4)) begin n_bad++; $display("FAIL ovf_level: %0d, required 4", level); end
        wait_drain(0, 40, "ovf_rd0");
        repeat (2) @(negedge clk);
        n_cmp++; if (level !== LW'(4))  begin n_bad++; $display("FAIL ovf_level_held: %0d, required 4", level); end
        n_cmp++; if (wr_full !== 1'b1) begin n_bad++; $display("FAIL ovf_full_held: %b, required 1", wr_full); end
        req = 2'b11;
        wait_drain(1, 40, "ovf_rd1");
        repeat (3) @(negedge clk);
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL ovf_empty: %b, required 1", empty); end
        n_cmp++; if (level !== '0)   begin n_bad++; $display("FAIL ovf_level_end: %0d, required 0", level); end
`ifdef REQ_ACK_BROADCAST_RESPONDER_STATS_EN
        n_cmp++; if (count !== {32'd4, 32'd4}) begin n_bad++; $display("FAIL stats_count: %h, required {4,4}", count); end
        n_cmp++; if (drop_count !== 32'd1)     begin n_bad++; $display("FAIL stats_drop: %0d, required 1", drop_count); end
`endif
        req = '0;
    endtask

    task automatic test_full_retire();
        do_reset(1);
        req = 2'b01;
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_data = DW'(32'hA0 + i);
            push_exp(wr_data);
            @(negedge clk);
        end
        wr_en = 1'b0;
        wait_drain(0, 40, "fr_rd0");
        repeat (2) @(negedge clk);
        n_cmp++; if (wr_full !== 1'b1) begin n_bad++; $display("FAIL fr_full: %b, required 1", wr_full); end
        req = 2'b11;
        @(negedge clk);
        n_cmp++; if (ack[1] !== 1'b1) begin n_bad++; $display("FAIL fr_ack1: %b, required 1", ack[1]); end
        // Tail retires on the coming edge while the write still sees a full buffer.
        req     = 2'b01;
        wr_en   = 1'b1;
        wr_data = 32'hB0;
        @(negedge clk);
        n_cmp++; if (level !== LW'(3)) begin n_bad++; $display("FAIL fr_level_rej: %0d, required 3", level); end
        n_cmp++; if (wr_full !== 1'b0) begin n_bad++; $display("FAIL fr_full_rej: %b, required 0", wr_full); end
        wr_data = 32'hB1;
        push_exp(wr_data);
        @(negedge clk);
        wr_en = 1'b0;
        n_cmp++; if (level !== LW'(4)) begin n_bad++; $display("FAIL fr_level_acc: %0d, required 4", level); end
        req = 2'b11;
        wait_drain(0, 60, "fr_end");
        wait_drain(1, 60, "fr_end");
        repeat (3) @(negedge clk);
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL fr_empty: %b, required 1", empty); end
        req = '0;
    endtask

    task automatic test_wrap();
        int sent = 0;
        int cyc  = 0;
        int over = 0;
        do_reset(1);
        while (sent < 20 && cyc < 2000) begin
            req = 2'($urandom_range(3, 0));
            if (wr_full === 1'b0) begin
                wr_en   = 1'b1;
                wr_data = DW'(sent);
                push_exp(wr_data);
                sent++;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if ($isunknown(level) || level > LW'(4)) over++;
        end
        wr_en = 1'b0;
        n_cmp++; if (sent != 20) begin n_bad++; $display("FAIL wrap_sent: %0d words, required 20", sent); end
        n_cmp++; if (over != 0)  begin n_bad++; $display("FAIL wrap_level: %0d cycles above 4, required 0", over); end
        req = 2'b11;
        wait_drain(0, 200, "wrap");
        wait_drain(1, 200, "wrap");
        repeat (3) @(negedge clk);
        for (int r = 0; r < NR; r++) begin
            n_cmp++;
            if (rx_cnt[r] != 20) begin n_bad++; $display("FAIL wrap_count rd%0d: %0d words, required 20", r, rx_cnt[r]); end
        end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL wrap_empty: %b, required 1", empty); end
        req = '0;
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1'b1;
            wr_data = DW'(32'hC0 + i);
            push_exp(wr_data);
            @(negedge clk);
        end
        wr_en = 1'b0;
        req   = 2'b01;
        @(negedge clk);
        n_cmp++; if (ack[0] !== 1'b1) begin n_bad++; $display("FAIL mid_ack_pending: %b, required 1", ack[0]); end
        do_reset(1);
        n_cmp++; if (ack !== '0)      begin n_bad++; $display("FAIL mid_ack: %b, required 0", ack); end
        n_cmp++; if (dout !== '0)     begin n_bad++; $display("FAIL mid_dout: %h, required 0", dout); end
        n_cmp++; if (level !== '0)    begin n_bad++; $display("FAIL mid_level: %0d, required 0", level); end
        n_cmp++; if (empty !== 1'b1)  begin n_bad++; $display("FAIL mid_empty: %b, required 1", empty); end
        req     = 2'b11;
        wr_en   = 1'b1;
        wr_data = 32'hAA;
        push_exp(wr_data);
        @(negedge clk);
        wr_en = 1'b0;
        wait_drain(0, 20, "mid");
        wait_drain(1, 20, "mid");
        repeat (2) @(negedge clk);
        for (int r = 0; r < NR; r++) begin
            n_cmp++;
            if (rx_cnt[r] != 1) begin n_bad++; $display("FAIL mid_count rd%0d: %0d words, required 1", r, rx_cnt[r]); end
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_retire();
        test_wrap();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
